// File: rtl/line_fill_unit_pkg.sv
// Shared types and constants for the line fill unit: FSM states, default widths
// and the fixed bit positions inside an 8-byte line.
package line_fill_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int WORD_W_DEF       = 32;
  localparam int LINE_W_DEF       = 2 * WORD_W_DEF;
  localparam int LINE_OFFSET_BITS = 3;
  localparam int WORD_SEL_BIT     = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_A     = 3'd1,
    REQ_B     = 3'd2,
    RESP      = 3'd3,
    WAIT_DROP = 3'd4
  } lfu_state_e;

endpackage

// File: rtl/line_fill_unit_if.sv
// Cache-side miss/fill signals and backing-memory req/ack port of the line fill unit.
// slave = the fill unit's view, master = the cache/memory side driving it.
interface line_fill_unit_if
  import line_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
);
  logic                  arvalid;
  logic [ADDR_W-1:0]     addr_mm;
  logic [2*WORD_W-1:0]   data_mm;
  logic                  rvalid_mm;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ack;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  busy;

  modport slave (
    input  arvalid, addr_mm, mem_ack, mem_rdata,
    output data_mm, rvalid_mm, mem_req, mem_addr, busy
  );

  modport master (
    output arvalid, addr_mm, mem_ack, mem_rdata,
    input  data_mm, rvalid_mm, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/line_fill_unit.sv
// Line fill unit: fetches the two 32-bit words of a missed 8-byte line and presents
// them as one 64-bit fill. Optional macro LINE_FILL_CRITICAL_WORD_FIRST_EN fetches the missed word first.
module line_fill_unit
  import line_fill_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  line_fill_unit_if.slave    bus_io
);

  localparam int LINE_W = 2 * WORD_W;

  lfu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                req_off;
  logic                first_off;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  logic                sel_q, sel_d;
  assign first_off = sel_q;
`else
  assign first_off = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      data_q      <= '0;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
      sel_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      data_q      <= data_d;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
      sel_q       <= sel_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    data_d      = data_q;
    req_off     = 1'b0;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    sel_d       = sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_io.arvalid) begin
          line_addr_d = {bus_io.addr_mm[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
          sel_d       = bus_io.addr_mm[WORD_SEL_BIT];
`endif
          state_d     = REQ_A;
        end
      end
      REQ_A, REQ_B: begin
        // REQ_B always fetches the word REQ_A did not; each word lands in its fixed half.
        req_off = (state_q == REQ_A) ? first_off : ~first_off;
        if (bus_io.mem_ack) begin
          if (req_off) data_d[WORD_W-1:0]      = bus_io.mem_rdata;
          else         data_d[LINE_W-1:WORD_W] = bus_io.mem_rdata;
          state_d = (state_q == REQ_A) ? REQ_B : RESP;
        end
      end
      RESP:      state_d = WAIT_DROP;
      WAIT_DROP: if (!bus_io.arvalid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Word select is OR-ed into a line-aligned address, so it can never carry out of the line.
  assign bus_io.mem_req   = (state_q == REQ_A) || (state_q == REQ_B);
  assign bus_io.mem_addr  = bus_io.mem_req ? (line_addr_q | (ADDR_W'(req_off) << WORD_SEL_BIT)) : '0;
  assign bus_io.rvalid_mm = (state_q == RESP);
  assign bus_io.busy      = (state_q != IDLE);
  assign bus_io.data_mm   = data_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed vector table, reset corner case,
// and randomized fills against a word-level memory/line model.
module tb_line_fill_unit;

  logic clk;
  logic rst_n;

  line_fill_unit_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  line_fill_unit #(.ADDR_W(32), .WORD_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] memory [logic [31:0]];
  logic [31:0] addr_log [$];
  int          waits [2];
  int          widx;
  int          wait_left;
  bit          cur_valid;
  logic [31:0] cur_addr;
  bit          stray_ack;

  typedef struct {
    logic [31:0] addr;
    int          w0;
    int          w1;
    int          drop_at;
    int          hold;
    bit          scramble;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] a_lo;
    logic [31:0] a_hi;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tv [7];

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (memory.exists(a)) return memory[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: memory responder reacts to the request visible now, then advance to next negedge.
  task automatic tick();
    if (stray_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
    end else if (bus.mem_req) begin
      if (!cur_valid) begin
        cur_valid = 1'b1;
        cur_addr  = bus.mem_addr;
        wait_left = waits[widx];
      end else begin
        check("mem_addr_stable", bus.mem_addr, cur_addr);
      end
      if (wait_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = fetch(cur_addr);
        addr_log.push_back(cur_addr);
        cur_valid = 1'b0;
        if (widx < 1) widx++;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      if (cur_valid) check("mem_req_held", bus.mem_req, 1'b1);
      bus.mem_ack = 1'b0;
      cur_valid   = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_responder();
    cur_valid   = 1'b0;
    widx        = 0;
    wait_left   = 0;
    bus.mem_ack = 1'b0;
    addr_log.delete();
  endtask

  task automatic do_fill(input string tag, input logic [31:0] addr, input int w0, input int w1,
                         input int drop_at, input int hold, input bit scramble,
                         input logic [31:0] exp_first, input logic [31:0] exp_second,
                         input logic [63:0] exp_data, input int exp_lat);
    int rv_t;
    clear_responder();
    waits[0] = w0;
    waits[1] = w1;
    bus.addr_mm = addr;
    bus.arvalid = 1'b1;
    rv_t = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (bus.rvalid_mm) begin
        rv_t = t;
        break;
      end
      if (t == drop_at) bus.arvalid = 1'b0;
      if (scramble) bus.addr_mm = $urandom;
    end
    if (rv_t == 0) begin
      check({tag, "_rvalid_timeout"}, 1'b0, 1'b1);
      bus.arvalid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_responder();
      return;
    end
    check({tag, "_latency"}, rv_t, exp_lat);
    check({tag, "_data"}, bus.data_mm, exp_data);
    check({tag, "_req_count"}, addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check({tag, "_addr_first"}, addr_log[0], exp_first);
      check({tag, "_addr_second"}, addr_log[1], exp_second);
    end
    check({tag, "_req_low_resp"}, bus.mem_req, 1'b0);
    tick();
    check({tag, "_rvalid_one_cycle"}, bus.rvalid_mm, 1'b0);
    check({tag, "_busy_wait_drop"}, bus.busy, 1'b1);
    if (bus.arvalid) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check({tag, "_no_refill"}, {bus.mem_req, bus.rvalid_mm, bus.busy}, 3'b001);
      end
      bus.arvalid = 1'b0;
    end
    tick();
    check({tag, "_idle_after_drop"}, bus.busy, 1'b0);
    check({tag, "_data_hold"}, bus.data_mm, exp_data);
  endtask

  function automatic bit cwf_en();
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [31:0] a, base, first;
    int          r, drop;

    rst_n         = 1'b0;
    bus.arvalid   = 1'b0;
    bus.addr_mm   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    stray_ack     = 1'b0;
    clear_responder();
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.mem_req, bus.rvalid_mm, bus.busy}, 3'b000);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_data", bus.data_mm, 64'h0);
    rst_n = 1'b1;
    tick();

    //                addr          w0 w1 drop hold scr  rd0 (off 0)   rd1 (off 4)   a_lo          a_hi          exp_data                 lat
    tv[0] = '{32'h0000_1234, 0, 0, -1, 0, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_1230, 32'h0000_1234, 64'hAAAA_0001_BBBB_0002, 3};
    tv[1] = '{32'h0000_1234, 3, 3, -1, 0, 1'b0, 32'hC0DE_0003, 32'hC0DE_0004, 32'h0000_1230, 32'h0000_1234, 64'hC0DE_0003_C0DE_0004, 9};
    tv[2] = '{32'h0000_2004, 0, 0, -1, 0, 1'b0, 32'h2222_2222, 32'h1111_1111, 32'h0000_2000, 32'h0000_2004, 64'h2222_2222_1111_1111, 3};
    tv[3] = '{32'h0000_0100, 1, 0, -1, 5, 1'b0, 32'h0101_0101, 32'h0202_0202, 32'h0000_0100, 32'h0000_0104, 64'h0101_0101_0202_0202, 4};
    tv[4] = '{32'h0000_0ABC, 2, 1,  1, 0, 1'b1, 32'h3333_4444, 32'h5555_6666, 32'h0000_0AB8, 32'h0000_0ABC, 64'h3333_4444_5555_6666, 6};
    tv[5] = '{32'h0000_0040, 0, 0, -1, 0, 1'b0, 32'h4040_4040, 32'h4444_4444, 32'h0000_0040, 32'h0000_0044, 64'h4040_4040_4444_4444, 3};
    tv[6] = '{32'hFFFF_FFFF, 0, 0, -1, 2, 1'b0, 32'h7E7E_7E7E, 32'h8181_8181, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 64'h7E7E_7E7E_8181_8181, 3};

    for (int i = 0; i < 7; i++) begin
      memory[tv[i].a_lo] = tv[i].rd0;
      memory[tv[i].a_hi] = tv[i].rd1;
      if (cwf_en() && tv[i].addr[2])
        do_fill($sformatf("vec%0d", i), tv[i].addr, tv[i].w0, tv[i].w1, tv[i].drop_at, tv[i].hold,
                tv[i].scramble, tv[i].a_hi, tv[i].a_lo, tv[i].exp_data, tv[i].exp_lat);
      else
        do_fill($sformatf("vec%0d", i), tv[i].addr, tv[i].w0, tv[i].w1, tv[i].drop_at, tv[i].hold,
                tv[i].scramble, tv[i].a_lo, tv[i].a_hi, tv[i].exp_data, tv[i].exp_lat);
    end

    // Reset while the second word is outstanding, then stray acks while idle.
    clear_responder();
    waits[0] = 0;
    waits[1] = 5;
    bus.addr_mm = 32'h0000_3000;
    bus.arvalid = 1'b1;
    repeat (3) tick();
    check("rst_pre_req_b", {bus.mem_req, bus.busy, bus.mem_addr}, {2'b11, 32'h0000_3004});
    rst_n       = 1'b0;
    bus.arvalid = 1'b0;
    #1;
    check("rst_async_outputs", {bus.mem_req, bus.busy, bus.rvalid_mm}, 3'b000);
    check("rst_async_mem_addr", bus.mem_addr, 32'h0);
    check("rst_async_data", bus.data_mm, 64'h0);
    clear_responder();
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stray_ack_ignored", {bus.mem_req, bus.busy, bus.rvalid_mm}, 3'b000);
      check("stray_ack_data", bus.data_mm, 64'h0);
    end
    stray_ack = 1'b0;
    clear_responder();
    tick();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if (i % 3 == 0) a = a & 32'h0000_00FF;
      base  = a & 32'hFFFF_FFF8;
      first = (cwf_en() && a[2]) ? (base | 32'h4) : base;
      r     = $urandom_range(0, 2);
      drop  = (r == 0) ? -1 : r;
      waits[0] = $urandom_range(0, 3);
      waits[1] = $urandom_range(0, 3);
      begin
        int w0, w1;
        w0 = waits[0];
        w1 = waits[1];
        do_fill($sformatf("rand%0d", i), a, w0, w1, drop, $urandom_range(0, 4),
                1'($urandom_range(0, 1)), first, first ^ 32'h4,
                {fetch(base), fetch(base | 32'h4)}, 3 + w0 + w1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
